ff_ram_mp: RTL



---
 rtl/ff_ram_mp_if.sv | 39 +++
 rtl/ff_ram_mp.sv | 122 ++++++++++++
 2 files changed

// File: rtl/ff_ram_mp_if.sv
// OBI-style bus bundle for ff_ram_mp: one read/write data port plus
// NUM_IPORTS read-only fetch/DMA ports, flattened per port.
interface ff_ram_mp_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_IPORTS = 1
);
    localparam int BE_W = DATA_WIDTH / 8;

    logic                             sram_d_req_i;
    logic                             sram_d_gnt_o;
    logic [31:0]                      sram_d_addr_i;
    logic                             sram_d_we_i;
    logic [BE_W-1:0]                  sram_d_be_i;
    logic [DATA_WIDTH-1:0]            sram_d_wdata_i;
    logic                             sram_d_rvalid_o;
    logic [DATA_WIDTH-1:0]            sram_d_rdata_o;
    logic                             sram_d_err_o;

    logic [NUM_IPORTS-1:0]            sram_i_req_i;
    logic [NUM_IPORTS-1:0]            sram_i_gnt_o;
    logic [32*NUM_IPORTS-1:0]         sram_i_addr_i;
    logic [NUM_IPORTS-1:0]            sram_i_rvalid_o;
    logic [DATA_WIDTH*NUM_IPORTS-1:0] sram_i_rdata_o;
    logic [NUM_IPORTS-1:0]            sram_i_err_o;

    modport master (
        output sram_d_req_i, sram_d_addr_i, sram_d_we_i, sram_d_be_i, sram_d_wdata_i,
        input  sram_d_gnt_o, sram_d_rvalid_o, sram_d_rdata_o, sram_d_err_o,
        output sram_i_req_i, sram_i_addr_i,
        input  sram_i_gnt_o, sram_i_rvalid_o, sram_i_rdata_o, sram_i_err_o
    );

    modport slave (
        input  sram_d_req_i, sram_d_addr_i, sram_d_we_i, sram_d_be_i, sram_d_wdata_i,
        output sram_d_gnt_o, sram_d_rvalid_o, sram_d_rdata_o, sram_d_err_o,
        input  sram_i_req_i, sram_i_addr_i,
        output sram_i_gnt_o, sram_i_rvalid_o, sram_i_rdata_o, sram_i_err_o
    );
endinterface

// File: rtl/ff_ram_mp.sv
// Multi-port flip-flop SRAM: one R/W data port, NUM_IPORTS read ports, fixed read latency.
// Optional same-cycle write-to-read forwarding is enabled by defining FF_RAM_MP_WFWD_EN.
module ff_ram_mp #(
    parameter logic [31:0] SRAM_BASE_ADDR = 32'h8000_0000,
    parameter int          SRAM_SIZE      = 4096,
    parameter int          DATA_WIDTH     = 32,
    parameter int          NUM_IPORTS     = 1,
    parameter int          READ_LATENCY   = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    ff_ram_mp_if.slave  bus,
    output logic        illegal_memory_o
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int WORDS = SRAM_SIZE / BE_W;
    localparam int AW    = $clog2(WORDS);
    localparam int LBE   = $clog2(BE_W);
    localparam int NP    = NUM_IPORTS + 1;
    localparam int RL    = READ_LATENCY;
    localparam logic [32:0] LO = {1'b0, SRAM_BASE_ADDR};
    localparam logic [32:0] HI = LO + 33'(SRAM_SIZE);
    localparam logic [DATA_WIDTH-1:0] BAD = {(DATA_WIDTH/32){32'hDEADBEEF}};

    logic [DATA_WIDTH-1:0] mem [WORDS];

    logic [NP-1:0]         req;
    logic [NP-1:0]         legal;
    logic [NP-1:0]         err_last;
    logic [31:0]           addr     [NP];
    logic [AW-1:0]         idx      [NP];
    logic [DATA_WIDTH-1:0] rd_word  [NP];
    logic [DATA_WIDTH-1:0] fwd_word [NP];
    logic [DATA_WIDTH-1:0] st0_data [NP];
    logic                  d_wr_ok;

    // Port 0 is the data port; ports 1..NP-1 are the read-only ports.
    logic                  vld_reg  [NP][RL];
    logic                  err_reg  [NP][RL];
    logic [DATA_WIDTH-1:0] dat_reg  [NP][RL];

    assign d_wr_ok = bus.sram_d_req_i & bus.sram_d_we_i & legal[0];

    genvar gi;
    generate
        for (gi = 0; gi < NP; gi++) begin : g_port
            if (gi == 0) begin : g_d
                assign req[gi]      = bus.sram_d_req_i;
                assign addr[gi]     = bus.sram_d_addr_i;
                assign fwd_word[gi] = rd_word[gi];
                // Write responses carry zero data even when illegal.
                assign st0_data[gi] = bus.sram_d_we_i ? '0 : (legal[gi] ? fwd_word[gi] : BAD);
            end else begin : g_i
                assign req[gi]      = bus.sram_i_req_i[gi-1];
                assign addr[gi]     = bus.sram_i_addr_i[32*(gi-1) +: 32];
`ifdef FF_RAM_MP_WFWD_EN
                logic [DATA_WIDTH-1:0] merged;
                always_comb begin
                    merged = rd_word[gi];
                    if (d_wr_ok && (idx[0] == idx[gi])) begin
                        for (int b = 0; b < BE_W; b++) begin
                            if (bus.sram_d_be_i[b]) merged[8*b +: 8] = bus.sram_d_wdata_i[8*b +: 8];
                        end
                    end
                end
                assign fwd_word[gi] = merged;
`else
                assign fwd_word[gi] = rd_word[gi];
`endif
                assign st0_data[gi] = legal[gi] ? fwd_word[gi] : BAD;
                assign bus.sram_i_gnt_o[gi-1]                        = 1'b1;
                assign bus.sram_i_rvalid_o[gi-1]                     = vld_reg[gi][RL-1];
                assign bus.sram_i_err_o[gi-1]                        = err_reg[gi][RL-1];
                assign bus.sram_i_rdata_o[DATA_WIDTH*(gi-1) +: DATA_WIDTH] = dat_reg[gi][RL-1];
            end

            // 33-bit compare so a window touching the top of the map cannot wrap.
            assign legal[gi]    = ({1'b0, addr[gi]} >= LO) && ({1'b0, addr[gi]} < HI);
            assign idx[gi]      = AW'((addr[gi] - SRAM_BASE_ADDR) >> LBE);
            assign rd_word[gi]  = mem[idx[gi]];
            assign err_last[gi] = err_reg[gi][RL-1];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (d_wr_ok) begin
            for (int b = 0; b < BE_W; b++) begin
                if (bus.sram_d_be_i[b]) mem[idx[0]][8*b +: 8] <= bus.sram_d_wdata_i[8*b +: 8];
            end
        end
    end

    // Data registers load only with a valid beat so rdata holds between responses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int p = 0; p < NP; p++) begin
                for (int s = 0; s < RL; s++) begin
                    vld_reg[p][s] <= 1'b0;
                    err_reg[p][s] <= 1'b0;
                    dat_reg[p][s] <= '0;
                end
            end
        end else begin
            for (int p = 0; p < NP; p++) begin
                vld_reg[p][0] <= req[p];
                err_reg[p][0] <= req[p] & ~legal[p];
                if (req[p]) dat_reg[p][0] <= st0_data[p];
                for (int s = 1; s < RL; s++) begin
                    vld_reg[p][s] <= vld_reg[p][s-1];
                    err_reg[p][s] <= err_reg[p][s-1];
                    if (vld_reg[p][s-1]) dat_reg[p][s] <= dat_reg[p][s-1];
                end
            end
        end
    end

    assign bus.sram_d_gnt_o    = 1'b1;
    assign bus.sram_d_rvalid_o = vld_reg[0][RL-1];
    assign bus.sram_d_err_o    = err_reg[0][RL-1];
    assign bus.sram_d_rdata_o  = dat_reg[0][RL-1];
    assign illegal_memory_o    = |err_last;
endmodule
